scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Scan-test sequencer that sits directly upstream of a chain of scan flip-flops. It drives the chain's SE and SI pins and gates the chain clock.
- It consumes the chain's scan-out (SO), shifting patterns in LSB first, issuing one capture cycle, then unloading the response while the next pattern loads.
- Unloaded bits are compared against expected data, and the block reports a pass/fail count for BIST-style on-chip test of digital blocks.

Parameters:
- CHAIN_LEN, 32, number of scan flops in the chain (>=2).
- CNT_W, 6, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN.
- FCNT_W, 16, fail-counter width.

Ports:
- CLK  input  1  rising-edge clock, shared with the chain.
- RN  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a test session.
- pat_valid  input  1  pattern available.
- pat_ready  output  1  pattern accepted this cycle (valid&ready handshake).
- pat_data  input  CHAIN_LEN  stimulus; bit 0 shifted first.
- exp_data  input  CHAIN_LEN  expected captured response for the same pattern; bit 0 emerges first.
- pat_last  input  1  marks the final pattern; sampled with pat_data.
- chain_ce  output  1  chain clock enable, consumed by an ICG outside this block.
- SE  output  1  scan enable to the chain.
- SI  output  1  scan-in to the chain head.
- SO  input  1  scan-out from the chain tail.
- busy  output  1  high from the start pulse until done.
- done  output  1  one-cycle pulse at session end.
- fail_cnt  output  FCNT_W  count of mismatching bits; saturating.

Behaviour:
- Reset (RN=0, async): state IDLE; all outputs 0; fail_cnt=0; shift registers and prev_valid cleared. Reset mid-session aborts the session with no done pulse.
- All outputs are registered.
- States and transitions:
  - IDLE: start -> LOAD. start is ignored when not in IDLE.
  - LOAD: chain_ce=0, SE=0, pat_ready=1.
    - On pat_valid: latch pat_data into stim_sr, exp_data into exp_next, pat_last into last_f; -> SHIFT with cnt=0.
    - While waiting, the chain is frozen (ce=0), so stalls are harmless.
  - SHIFT: chain_ce=1, SE=1, SI=stim_sr[0].
    - stim_sr shifts right each cycle, filling with 0.
    - If prev_valid, compare SO against exp_sr[0]; on mismatch fail_cnt += 1, saturating at all-ones. exp_sr shifts right.
    - After CHAIN_LEN cycles -> CAPTURE.
  - CAPTURE: exactly one cycle with chain_ce=1, SE=0, SI=0; the functional D is captured.
    - exp_sr <= exp_next; prev_valid <= 1.
    - If last_f -> UNLOAD with cnt=0; else -> LOAD.
  - UNLOAD: as SHIFT but SI=0 and no new pattern; CHAIN_LEN compared cycles, then -> FIN.
  - FIN: done=1 for one cycle; busy drops the same cycle; prev_valid cleared; -> IDLE. fail_cnt holds until the next start, which clears it.
- Latency: each pattern costs CHAIN_LEN+1 chain cycles plus LOAD cycles (1 minimum when pat_valid is already high). The final unload costs CHAIN_LEN cycles.
- Alignment: SO sampled in shift cycle k is response bit k. The chain flop output is observed one cycle after SE rises in the chain model, so the bench chain model must match this convention.
- Comparison is skipped during the first pattern's SHIFT (prev_valid=0).
- pat_valid arriving together with pat_last on the first pattern is legal: the session is load, capture, unload.

Optional Feature:
- Macro: SCAN_CTRL_MISR_EN.
- Defined: adds output misr_sig [15:0], reset 0 and cleared on start. On every compared shift bit it updates as a 16-bit MISR with polynomial x^16+x^12+x^5+1, with SO XORed into bit 0. It is valid and stable from the done pulse. Comparison and fail_cnt are unchanged.
- Undefined: no misr_sig port and no MISR logic.

Decomposition:
- Package scan_ctrl_pkg: state enum (IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, FIN), MISR_POLY=16'h1021, MISR_W=16, default FCNT_W.
- Sub-module scan_misr: serial-input MISR with en, clr, din, and sig output. Instantiated only under SCAN_CTRL_MISR_EN.

Test Plan:
- Single pattern, CHAIN_LEN=32, chain model is a pure shift register (D = Q): pat=32'hA5A5_0F0F, exp=32'hA5A5_0F0F, pat_last=1 -> fail_cnt=0, done after 1+32+1+32 cycles from acceptance.
- Two patterns with exp bit 3 wrong on pattern 1 -> fail_cnt=1; with 3 wrong bits -> fail_cnt=3.
- pat_valid held low for 10 cycles between patterns -> chain_ce=0 and SE=0 throughout the stall; chain contents unchanged; result identical to the no-stall run.
- RN asserted mid-SHIFT (cnt=17) -> SE, chain_ce, busy and fail_cnt drop to 0 immediately; no done pulse; a new start runs cleanly.
- FCNT_W=4, all 32 bits mismatched -> fail_cnt saturates at 4'hF; start during busy is ignored.
- With SCAN_CTRL_MISR_EN and an all-zero response stream -> misr_sig=16'h0000. A single 1 in the last unloaded bit -> misr_sig=16'h0001.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan-chain sequencer.
// State encoding, MISR polynomial and default fail-counter width.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPTURE,
    UNLOAD,
    FIN
  } state_t;

  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
  localparam int FCNT_W_DEF = 16;

endpackage

// File: rtl/scan_misr.sv
// Serial-input MISR, x^16+x^12+x^5+1, din folded into bit 0.
// Used by scan_chain_ctrl when SCAN_CTRL_MISR_EN is defined.
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RN,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] fb;

  always_comb begin
    fb = sig[MISR_W-1] ? MISR_POLY : '0;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], 1'b0} ^ fb
           ^ {{(MISR_W-1){1'b0}}, din};
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan sequencer: load/shift/capture/unload with SO comparison.
// Define SCAN_CTRL_MISR_EN to add the misr_sig signature output.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6,
  parameter int FCNT_W    = FCNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  input  logic                 pat_last,
  output logic                 chain_ce,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 busy,
  output logic                 done,
  output logic [FCNT_W-1:0]    fail_cnt
`ifdef SCAN_CTRL_MISR_EN
  ,
  output logic [MISR_W-1:0]    misr_sig
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CHAIN_LEN-1:0] stim_sr, stim_d;
  logic [CHAIN_LEN-1:0] exp_sr, exp_sr_d;
  logic [CHAIN_LEN-1:0] exp_next, exp_next_d;
  logic last_f, last_d;
  logic prev_valid, pv_d;
  logic cmp;
  logic [FCNT_W-1:0] fail_d;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    stim_d     = stim_sr;
    exp_sr_d   = exp_sr;
    exp_next_d = exp_next;
    last_d     = last_f;
    pv_d       = prev_valid;
    fail_d     = fail_cnt;
    cmp        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          fail_d  = '0;
        end
      end
      LOAD: begin
        if (pat_valid) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          stim_d     = pat_data;
          exp_next_d = exp_data;
          last_d     = pat_last;
        end
      end
      SHIFT, UNLOAD: begin
        // SO carries the previous pattern's response, if any
        cmp      = prev_valid;
        stim_d   = stim_sr >> 1;
        exp_sr_d = exp_sr >> 1;
        cnt_d    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_d = (state == SHIFT) ? CAPTURE : FIN;
        end
      end
      CAPTURE: begin
        exp_sr_d = exp_next;
        pv_d     = 1'b1;
        cnt_d    = '0;
        state_d  = last_f ? UNLOAD : LOAD;
      end
      FIN: begin
        pv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cmp && (SO != exp_sr[0]) && (fail_cnt != '1)) begin
      fail_d = fail_cnt + FCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state      <= IDLE;
      cnt        <= '0;
      stim_sr    <= '0;
      exp_sr     <= '0;
      exp_next   <= '0;
      last_f     <= 1'b0;
      prev_valid <= 1'b0;
      fail_cnt   <= '0;
      pat_ready  <= 1'b0;
      chain_ce   <= 1'b0;
      SE         <= 1'b0;
      SI         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      stim_sr    <= stim_d;
      exp_sr     <= exp_sr_d;
      exp_next   <= exp_next_d;
      last_f     <= last_d;
      prev_valid <= pv_d;
      fail_cnt   <= fail_d;
      pat_ready  <= (state_d == LOAD);
      chain_ce   <= state_d inside {SHIFT, CAPTURE, UNLOAD};
      SE         <= state_d inside {SHIFT, UNLOAD};
      SI         <= (state_d == SHIFT) && stim_d[0];
      busy       <= state_d inside {LOAD, SHIFT, CAPTURE, UNLOAD};
      done       <= (state_d == FIN);
    end
  end

`ifdef SCAN_CTRL_MISR_EN
  logic misr_clr;

  always_comb begin
    misr_clr = (state == IDLE) && start;
  end

  scan_misr u_misr (
    .CLK (CLK),
    .RN  (RN),
    .en  (cmp),
    .clr (misr_clr),
    .din (SO),
    .sig (misr_sig)
  );
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: timeline model plus directed sessions.
// MISR checks are built when SCAN_CTRL_MISR_EN is defined.
module tb_scan_chain_ctrl;

  localparam int N = 32;

  logic CLK = 1'b0;
  logic RN = 1'b1;
  logic start = 1'b0;
  logic pat_valid = 1'b0;
  logic pat_last = 1'b0;
  logic [N-1:0] pat_data = '0;
  logic [N-1:0] exp_data = '0;
  logic SO;
  logic pat_ready, chain_ce, SE, SI, busy, done;
  logic [15:0] fail_cnt;
  logic rdy4, ce4, se4, si4, busy4, done4;
  logic [3:0] fail4;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0] misr_sig, misr4;
`endif

  logic [N-1:0] chain = '0;

  always #5 CLK = ~CLK;

  // Pure shift-register chain: D = Q, head takes SI, tail drives SO
  always @(posedge CLK) begin
    if (chain_ce) chain <= SE ? {chain[N-2:0], SI} : chain;
  end
  assign SO = chain[N-1];

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(6), .FCNT_W(16)) dut (
    .CLK(CLK), .RN(RN), .start(start),
    .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .exp_data(exp_data),
    .pat_last(pat_last), .chain_ce(chain_ce),
    .SE(SE), .SI(SI), .SO(SO),
    .busy(busy), .done(done), .fail_cnt(fail_cnt)
`ifdef SCAN_CTRL_MISR_EN
    , .misr_sig(misr_sig)
`endif
  );

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(6), .FCNT_W(4)) dut4 (
    .CLK(CLK), .RN(RN), .start(start),
    .pat_valid(pat_valid), .pat_ready(rdy4),
    .pat_data(pat_data), .exp_data(exp_data),
    .pat_last(pat_last), .chain_ce(ce4),
    .SE(se4), .SI(si4), .SO(SO),
    .busy(busy4), .done(done4), .fail_cnt(fail4)
`ifdef SCAN_CTRL_MISR_EN
    , .misr_sig(misr4)
`endif
  );

  typedef struct {
    logic rdy;
    logic ce;
    logic se;
    logic si;
    logic busy;
    logic done;
    int   fail;
  } exp_t;

  exp_t q[$];
  int idle_fail = 0;
  int checks = 0;
  int fails = 0;

  logic [N-1:0] pv[4];
  logic [N-1:0] ev[4];
  int sv[4];
  int np;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic push(input logic r, input logic c, input logic s,
                      input logic i, input logic b, input logic d,
                      input int f);
    exp_t e;
    e.rdy = r; e.ce = c; e.se = s; e.si = i;
    e.busy = b; e.done = d; e.fail = f;
    q.push_back(e);
  endtask

  // Expected per-cycle outputs of one session, from the first LOAD cycle
  task automatic plan();
    int f;
    logic [N-1:0] resp, expv;
    f = 0;
    resp = '0;
    expv = '0;
    for (int i = 0; i < np; i++) begin
      for (int s = 0; s <= sv[i]; s++) push(1, 0, 0, 0, 1, 0, f);
      for (int k = 0; k < N; k++) begin
        push(0, 1, 1, pv[i][k], 1, 0, f);
        if (i > 0 && resp[k] != expv[k]) f++;
      end
      push(0, 1, 0, 0, 1, 0, f);
      resp = pv[i];
      expv = ev[i];
    end
    for (int k = 0; k < N; k++) begin
      push(0, 1, 1, 0, 1, 0, f);
      if (resp[k] != expv[k]) f++;
    end
    push(0, 0, 0, 0, 0, 1, f);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      idle_fail = e.fail;
    end else begin
      e.rdy = 0; e.ce = 0; e.se = 0; e.si = 0;
      e.busy = 0; e.done = 0; e.fail = idle_fail;
    end
    chk("pat_ready", pat_ready, e.rdy);
    chk("chain_ce", chain_ce, e.ce);
    chk("SE", SE, e.se);
    chk("SI", SI, e.si);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("fail_cnt", fail_cnt, sat(e.fail, 16));
    chk("fail_cnt4", fail4, sat(e.fail, 4));
  end

  task automatic start_sess();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    plan();
  endtask

  task automatic feed(input int lo, input int hi);
    logic [N-1:0] snap;
    int n;
    for (int i = lo; i < hi; i++) begin
      n = 0;
      while (!pat_ready && n < 300) begin
        @(posedge CLK); #1;
        n++;
      end
      chk("pat_ready_wait", pat_ready, 1);
      if (!pat_ready) return;
      snap = chain;
      repeat (sv[i]) begin
        @(posedge CLK); #1;
      end
      if (sv[i] > 0) chk("chain_hold", int'(chain == snap), 1);
      pat_valid = 1'b1;
      pat_data = pv[i];
      exp_data = ev[i];
      pat_last = (i == np - 1);
      @(posedge CLK); #1;
      pat_valid = 1'b0;
      pat_data = '0;
      exp_data = '0;
      pat_last = 1'b0;
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic idle_gap();
    repeat (3) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic run_all(output int n);
    start_sess();
    feed(0, np);
    wait_done(n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dn;
    for (int i = 0; i < 4; i++) sv[i] = 0;

    #2 RN = 1'b0;
    #1;
    chk("rst_pat_ready", pat_ready, 0);
    chk("rst_chain_ce", chain_ce, 0);
    chk("rst_SE", SE, 0);
    chk("rst_SI", SI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
`ifdef SCAN_CTRL_MISR_EN
    chk("rst_misr", misr_sig, 0);
`endif
    repeat (3) @(posedge CLK);
    #1 RN = 1'b1;
    idle_gap();

    // Single pattern, matching expectation
    np = 1;
    pv[0] = 32'hA5A5_0F0F; ev[0] = 32'hA5A5_0F0F;
    run_all(n);
    chk("single_latency", n + 1, 1 + 32 + 1 + 32);
    chk("single_fail", fail_cnt, 0);
    idle_gap();

    // Two patterns, one wrong expected bit on the first
    np = 2;
    pv[0] = 32'hDEAD_BEEF; ev[0] = 32'hDEAD_BEEF ^ 32'h0000_0008;
    pv[1] = 32'h0F0F_1234; ev[1] = 32'h0F0F_1234;
    run_all(n);
    chk("two_pat_1bit", fail_cnt, 1);
    idle_gap();

    // Three wrong bits
    ev[0] = 32'hDEAD_BEEF ^ 32'h0001_0108;
    run_all(n);
    chk("two_pat_3bit", fail_cnt, 3);
    idle_gap();

    // Same, with a 10-cycle stall before the second pattern
    sv[1] = 10;
    run_all(n);
    chk("stall_3bit", fail_cnt, 3);
    sv[1] = 0;
    idle_gap();

    // Reset in the middle of the second pattern's shift
    ev[0] = 32'hDEAD_BEEF ^ 32'h0000_0007;
    start_sess();
    feed(0, 2);
    repeat (17) @(posedge CLK);
    #1;
    chk("cnt17_SE", SE, 1);
    chk("cnt17_fail", fail_cnt, 3);
    RN = 1'b0;
    #1;
    chk("abort_SE", SE, 0);
    chk("abort_ce", chain_ce, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fail", fail_cnt, 0);
    chk("abort_fail4", fail4, 0);
    q.delete();
    idle_fail = 0;
    repeat (3) @(posedge CLK);
    #1 RN = 1'b1;
    dn = 0;
    repeat (20) begin
      @(posedge CLK); #1;
      dn += done;
    end
    chk("no_done_after_abort", dn, 0);

    // Clean rerun after the abort
    np = 1;
    pv[0] = 32'hA5A5_0F0F; ev[0] = 32'hA5A5_0F0F;
    run_all(n);
    chk("rerun_latency", n + 1, 66);
    chk("rerun_fail", fail_cnt, 0);
    idle_gap();

    // All 32 bits wrong: 4-bit counter saturates; start while busy ignored
    np = 2;
    pv[0] = 32'h1234_5678; ev[0] = ~32'h1234_5678;
    pv[1] = 32'h0000_0000; ev[1] = 32'h0000_0000;
    start_sess();
    feed(0, 2);
    repeat (5) @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    wait_done(n);
    chk("sat_fail4", fail4, 15);
    chk("sat_fail16", fail_cnt, 32);
    idle_gap();

`ifdef SCAN_CTRL_MISR_EN
    np = 1;
    pv[0] = 32'h0000_0000; ev[0] = 32'h0000_0000;
    run_all(n);
    chk("misr_zero", misr_sig, 16'h0000);
    idle_gap();
    pv[0] = 32'h8000_0000; ev[0] = 32'h8000_0000;
    run_all(n);
    chk("misr_last_one", misr_sig, 16'h0001);
    idle_gap();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
